// File: rtl/wb_ctl_bridge.sv
// Wishbone slave front end: opcode register at window word 0, remaining words
// forwarded to a backend over valid/ready handshakes. Optional macro: WB_CTL_ERR_EN.
module wb_ctl_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NUM_WORDS = 256,
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 32,
  parameter int          TIMEOUT   = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [DATA_W/8-1:0] wbs_sel_i,
  input  logic [DATA_W-1:0]   wbs_dat_i,
  input  logic [31:0]         wbs_adr_i,
  output logic                wbs_ack_o,
  output logic [DATA_W-1:0]   wbs_dat_o,
`ifdef WB_CTL_ERR_EN
  output logic                wbs_err_o,
`endif
  output logic                config_en,
  output logic [DATA_W-1:0]   opcode_o,
  output logic                be_req_valid,
  input  logic                be_req_ready,
  output logic                be_we,
  output logic [ADDR_W-1:0]   be_addr,
  output logic [DATA_W-1:0]   be_wdata,
  output logic [DATA_W/8-1:0] be_sel,
  input  logic                be_rsp_valid,
  input  logic [DATA_W-1:0]   be_rdata
);

  localparam int NB = DATA_W / 8;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR} + 33'd4;
  localparam logic [32:0] WIN_HI = {1'b0, BASE_ADDR} + 33'(4 * (NUM_WORDS + 1));

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ACK} state_t;

  state_t            r_state, w_state_nxt;
  logic [TW-1:0]     r_timer;
  logic              r_abort;
  logic [DATA_W-1:0] r_rdata;
  logic [31:0]       w_word, w_off;
  logic              w_cyc_stb, w_hit_opc, w_hit_win, w_timeout;
  logic              w_start_opc, w_start_win, w_start_miss, w_take_rsp, w_timeout_hit;

  assign w_cyc_stb = wbs_cyc_i & wbs_stb_i;
  assign w_word    = {wbs_adr_i[31:2], 2'b00};
  assign w_off     = w_word - BASE_ADDR - 32'd4;
  assign w_hit_opc = (w_word == BASE_ADDR);
  assign w_hit_win = ({1'b0, w_word} >= WIN_LO) && ({1'b0, w_word} < WIN_HI);
  assign w_timeout = (TIMEOUT != 0) && (r_timer == TO_LAST);
  assign config_en = w_cyc_stb && (wbs_adr_i == BASE_ADDR);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= S_IDLE;
    // NOTE: registers update with <= so every flop samples pre-edge values.
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches form.
    w_state_nxt   = r_state;
    w_start_opc   = 1'b0;
    w_start_win   = 1'b0;
    w_start_miss  = 1'b0;
    w_take_rsp    = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cyc_stb) begin
          if (w_hit_opc) begin
            w_start_opc = 1'b1;
            w_state_nxt = S_ACK;
          end else if (w_hit_win) begin
            w_start_win = 1'b1;
            w_state_nxt = S_REQ;
          end else begin
            w_start_miss = 1'b1;
            w_state_nxt  = S_ACK;
          end
        end
      end
      S_REQ: begin
        // A completed handshake stands even if the master gives up in that cycle.
        if (be_req_ready) begin
          if (be_we) w_state_nxt = wbs_cyc_i ? S_ACK : S_IDLE;
          else       w_state_nxt = S_WAIT;
        end else if (!wbs_cyc_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = S_ACK;
        end
      end
      S_WAIT: begin
        if (be_rsp_valid) begin
          w_take_rsp  = 1'b1;
          w_state_nxt = (r_abort || !wbs_cyc_i) ? S_IDLE : S_ACK;
        end else if (w_timeout) begin
          w_timeout_hit = 1'b1;
          w_state_nxt   = (r_abort || !wbs_cyc_i) ? S_IDLE : S_ACK;
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      opcode_o <= '0;
      be_we    <= 1'b0;
      be_addr  <= '0;
      be_wdata <= '0;
      be_sel   <= '0;
      r_rdata  <= '0;
      r_timer  <= '0;
      r_abort  <= 1'b0;
    end else begin
      if (w_start_opc && wbs_we_i) begin
        for (int b = 0; b < NB; b++)
          if (wbs_sel_i[b]) opcode_o[b*8 +: 8] <= wbs_dat_i[b*8 +: 8];
      end
      if (w_start_win) begin
        be_we    <= wbs_we_i;
        be_addr  <= ADDR_W'(w_off >> 2);
        be_wdata <= wbs_dat_i;
        be_sel   <= wbs_sel_i;
      end
      if (w_start_opc)                                     r_rdata <= wbs_we_i ? '0 : opcode_o;
      else if (w_start_win || w_start_miss || w_timeout_hit) r_rdata <= '0;
      else if (w_take_rsp)                                 r_rdata <= be_rdata;
      if (w_start_win)                                     r_timer <= '0;
      else if (r_state == S_REQ || r_state == S_WAIT)      r_timer <= r_timer + 1'b1;
      // Once the master leaves mid-read, the eventual response is swallowed.
      r_abort <= (w_state_nxt == S_WAIT) && (r_abort || !wbs_cyc_i);
    end
  end

  assign be_req_valid = (r_state == S_REQ);

`ifdef WB_CTL_ERR_EN
  logic r_err;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_err <= 1'b0;
    else            r_err <= w_start_miss | w_timeout_hit;
  end
  assign wbs_ack_o = (r_state == S_ACK) && !r_err;
  assign wbs_err_o = (r_state == S_ACK) && r_err;
`else
  assign wbs_ack_o = (r_state == S_ACK);
`endif

  assign wbs_dat_o = wbs_ack_o ? r_rdata : '0;

endmodule

// File: tb/tb_wb_ctl_bridge.sv
// Randomized bench for wb_ctl_bridge against a word-level bus/memory model;
// a second instance with TIMEOUT=4 and a dead backend exercises the timeout.
module tb_wb_ctl_bridge;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          NW   = 256;
`ifdef WB_CTL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cyc = 0, stb = 0, we = 0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_i = '0, adr = '0;

  logic        ack1, err1, cfg1, rv1, bwe1;
  logic [31:0] dat1, opc1, bwd1;
  logic [7:0]  ba1;
  logic [3:0]  bs1;
  logic        rr1 = 0, rsv1 = 0;
  logic [31:0] brd1 = '0;

  logic        ack2, err2, cfg2, rv2, bwe2;
  logic [31:0] dat2, opc2, bwd2;
  logic [7:0]  ba2;
  logic [3:0]  bs2;
  logic        rr2 = 0, rsv2 = 0;
  logic [31:0] brd2 = '0;

`ifndef WB_CTL_ERR_EN
  assign err1 = 1'b0;
  assign err2 = 1'b0;
`endif

  wb_ctl_bridge u_dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack1), .wbs_dat_o(dat1),
`ifdef WB_CTL_ERR_EN
    .wbs_err_o(err1),
`endif
    .config_en(cfg1), .opcode_o(opc1), .be_req_valid(rv1), .be_req_ready(rr1), .be_we(bwe1),
    .be_addr(ba1), .be_wdata(bwd1), .be_sel(bs1), .be_rsp_valid(rsv1), .be_rdata(brd1)
  );

  wb_ctl_bridge #(.TIMEOUT(4)) u_dut_to (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack2), .wbs_dat_o(dat2),
`ifdef WB_CTL_ERR_EN
    .wbs_err_o(err2),
`endif
    .config_en(cfg2), .opcode_o(opc2), .be_req_valid(rv2), .be_req_ready(rr2), .be_we(bwe2),
    .be_addr(ba2), .be_wdata(bwd2), .be_sel(bs2), .be_rsp_valid(rsv2), .be_rdata(brd2)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [NW];
  logic [31:0] be_mem  [NW];
  logic [31:0] ref_opc = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic check_reset(input string p);
    check({p, "_ack"},   32'(ack1), 32'd0);
    check({p, "_dat"},   dat1,      32'd0);
    check({p, "_opc"},   opc1,      32'd0);
    check({p, "_valid"}, 32'(rv1),  32'd0);
    check({p, "_be_we"}, 32'(bwe1), 32'd0);
    check({p, "_addr"},  32'(ba1),  32'd0);
    check({p, "_wdata"}, bwd1,      32'd0);
    check({p, "_sel"},   32'(bs1),  32'd0);
`ifdef WB_CTL_ERR_EN
    check({p, "_err"},   32'(err1), 32'd0);
`endif
  endtask

  // One bus transaction on u_dut with a reactive backend; called just after a posedge.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int rdy_dly, input int rsp_dly);
    logic [31:0] wa, off, exp_d;
    logic [7:0]  cap;
    bit          is_opc, is_win, exp_err;
    int          idx, exp_ack, exp_vcnt, n, vcnt, c, ack_n;
    bit          done;
    wa     = {a[31:2], 2'b00};
    is_opc = (wa == BASE);
    is_win = ({1'b0, wa} >= {1'b0, BASE} + 33'd4) && ({1'b0, wa} < {1'b0, BASE} + 33'(4 * (NW + 1)));
    off    = wa - BASE - 32'd4;
    idx    = int'(off >> 2);
    exp_d  = '0;
    exp_vcnt = is_win ? rdy_dly + 1 : 0;
    exp_err  = ERR_EN && !is_opc && !is_win;
    if (is_opc) begin
      exp_ack = 1;
      if (w) ref_opc = merge(ref_opc, d, s);
      else   exp_d = ref_opc;
    end else if (is_win) begin
      if (w) begin
        ref_mem[idx] = merge(ref_mem[idx], d, s);
        exp_ack = rdy_dly + 2;
      end else begin
        exp_d   = ref_mem[idx];
        exp_ack = rdy_dly + rsp_dly + 2;
      end
    end else begin
      exp_ack = 1;
    end

    we = w; adr = a; dat_i = d; sel = s; cyc = 1; stb = 1;
    #1 check("config_en", 32'(cfg1), 32'(a == BASE));
    n = 0; vcnt = 0; c = -1; ack_n = -1; done = 0; cap = '0;
    while (!done && n < 80) begin
      @(posedge clk); #1; n++;
      rr1 = 0; rsv1 = 0; brd1 = $urandom;
      if (ack_n >= 0) begin
        check("term_drop", 32'(ack1 | err1), 32'd0);
        check("dat_after", dat1, 32'd0);
        check("req_cycles", 32'(vcnt), 32'(exp_vcnt));
        if (is_opc) check("opcode", opc1, ref_opc);
        done = 1;
      end else if (ack1 | err1) begin
        ack_n = n;
        check("term_cycle", 32'(n), 32'(exp_ack));
        check("term_kind", {30'b0, ack1, err1}, {30'b0, !exp_err, exp_err});
        check("rdata", dat1, exp_d);
        cyc = 0; stb = 0; we = 0;
      end else begin
        check("dat_idle", dat1, 32'd0);
        if (c < 0) rsv1 = 1'($urandom_range(0, 1));
        if (rv1) begin
          vcnt++;
          check("be_addr", 32'(ba1), 32'(idx));
          check("be_we", 32'(bwe1), 32'(w));
          check("be_wdata", bwd1, d);
          check("be_sel", 32'(bs1), 32'(s));
          if (vcnt == rdy_dly + 1) begin
            rr1 = 1; c = n; cap = ba1;
            if (bwe1) be_mem[ba1] = merge(be_mem[ba1], bwd1, bs1);
          end
        end
        if (c >= 0 && !w && n == c + rsp_dly) begin
          rsv1 = 1; brd1 = be_mem[cap];
        end
      end
    end
    if (!done) begin
      check("xfer_budget", 32'd0, 32'd1);
      cyc = 0; stb = 0; rr1 = 0; rsv1 = 0;
    end
  endtask

  task automatic timeout_and_abort();
    int n, v2, t_n;
    adr = BASE + 32'd24; we = 0; sel = 4'hF; dat_i = $urandom; cyc = 1; stb = 1;
    rr1 = 0; rsv1 = 0;
    n = 0; v2 = 0; t_n = -1;
    while (n < 40 && t_n < 0) begin
      @(posedge clk); #1; n++;
      if (ack2 | err2) begin
        t_n = n;
        check("to_cycle", 32'(n), 32'd5);
        check("to_kind", {30'b0, ack2, err2}, {30'b0, !ERR_EN, ERR_EN});
        check("to_data", dat2, 32'd0);
        check("to_req_cycles", 32'(v2), 32'd4);
        check("to_valid_low", 32'(rv2), 32'd0);
        check("abort_pending_valid", 32'(rv1), 32'd1);
        cyc = 0; stb = 0;
      end else if (rv2) begin
        v2++;
      end
      check("abort_no_term", 32'(ack1 | err1), 32'd0);
    end
    if (t_n < 0) begin
      check("to_budget", 32'd0, 32'd1);
      cyc = 0; stb = 0;
    end
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_valid_low", 32'(rv1), 32'd0);
      check("abort_no_ack", 32'(ack1 | err1), 32'd0);
      check("to_after_valid", 32'(rv2), 32'd0);
    end
  endtask

  task automatic reset_mid_wait();
    int  n;
    bit  hs;
    adr = BASE + 32'd8; we = 0; sel = 4'hF; dat_i = '0; cyc = 1; stb = 1;
    n = 0; hs = 0;
    while (n < 20 && !hs) begin
      @(posedge clk); #1; n++;
      rr1 = 0; rsv1 = 0;
      if (rv1) begin rr1 = 1; hs = 1; end
    end
    if (!hs) check("rst_hs_budget", 32'd0, 32'd1);
    @(posedge clk); #1; rr1 = 0;
    @(posedge clk); #1;
    check("wait_no_ack", 32'(ack1 | err1), 32'd0);
    check("wait_no_valid", 32'(rv1), 32'd0);
    #2 rst_n = 0;
    #1 check_reset("rst_mid");
    cyc = 0; stb = 0; ref_opc = '0;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NW; i++) begin
      be_mem[i]  = $urandom;
      ref_mem[i] = be_mem[i];
    end
    be_mem[1]  = 32'h1357_9BDF;
    ref_mem[1] = 32'h1357_9BDF;

    repeat (3) @(posedge clk);
    #1 check_reset("reset");
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    xfer(1'b1, BASE,          32'hA5A5_1234, 4'b0011, 0, 1);
    xfer(1'b0, BASE,          32'h0,         4'hF,    0, 1);
    xfer(1'b1, BASE + 32'h10, 32'hCAFE_F00D, 4'hF,    3, 1);
    xfer(1'b0, BASE + 32'h08, 32'h0,         4'hF,    0, 2);
    xfer(1'b0, BASE + 32'h404, 32'h0,        4'hF,    0, 1);
    xfer(1'b0, BASE + 32'h400, 32'h0,        4'hF,    1, 1);
    xfer(1'b0, BASE + 32'h04,  32'h0,        4'hF,    0, 1);
    xfer(1'b0, BASE - 32'h04,  32'h0,        4'hF,    0, 1);
    xfer(1'b0, BASE + 32'h02,  32'h0,        4'hF,    0, 1);
    xfer(1'b1, BASE + 32'h14,  32'hFFFF_FFFF, 4'h0,   2, 1);
    xfer(1'b0, BASE + 32'h14,  32'h0,        4'hF,    0, 3);

    for (int t = 0; t < 40; t++) begin
      int          k;
      logic [31:0] a;
      logic [3:0]  s;
      k = int'($urandom_range(0, 9));
      if (k < 2)      a = BASE | 32'($urandom_range(0, 3));
      else if (k < 8) a = BASE + 32'd4 + 32'($urandom_range(0, NW - 1)) * 32'd4 + 32'($urandom_range(0, 3));
      else if (k < 9) a = BASE + 32'd4 * 32'(NW + 1) + 32'd4 * 32'($urandom_range(0, 15));
      else            a = $urandom;
      s = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      xfer(1'($urandom_range(0, 1)), a, $urandom, s,
           int'($urandom_range(0, 4)), int'($urandom_range(1, 4)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) begin @(posedge clk); #1; end
    timeout_and_abort();
    reset_mid_wait();
    xfer(1'b0, BASE,          32'h0, 4'hF, 0, 1);
    xfer(1'b0, BASE + 32'h08, 32'h0, 4'hF, 2, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
